// File: rtl/lsu_align.sv
// RV32I load/store alignment unit: turns byte-addressed LB..SW requests into one or two
// word accesses, merges split read data and returns the extended load result.
module lsu_align #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              mem_valid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err
);

    localparam int unsigned WORD_W = 32;
    localparam int unsigned PAIR_W = 2 * WORD_W;

    localparam logic [2:0] FUNC3_LB  = 3'b000;
    localparam logic [2:0] FUNC3_LH  = 3'b001;
    localparam logic [2:0] FUNC3_LBU = 3'b100;
    localparam logic [2:0] FUNC3_LHU = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LO,
        S_HI,
        S_LAST,
        S_RESP
    } state_t;

    state_t              state_q;
    logic                store_q;
    logic [2:0]          funct3_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [WORD_W-1:0]   wdata_q;
    logic [WORD_W-1:0]   buf_lo_q;
    logic [WORD_W-1:0]   buf_hi_q;
    logic [WORD_W-1:0]   resp_rdata_q;
    logic                err_q;

    logic                req_illegal;
    logic [1:0]          off;
    logic [3:0]          size_mask;
    logic [7:0]          mask;
    logic [PAIR_W-1:0]   data;
    logic                split;
    logic [ADDR_W-1:0]   lo_addr;
    logic [ADDR_W-1:0]   hi_addr;
    logic [PAIR_W-1:0]   rword;
    logic [WORD_W-1:0]   shifted;
    logic [WORD_W-1:0]   ext;
    logic [WORD_W-1:0]   resp_rdata_d;

    assign req_illegal = (req_funct3[1:0] == 2'b11) || (req_store && req_funct3[2]);

    // Byte-lane geometry of the latched request across the two-word window.
    assign off = addr_q[1:0];

    always_comb begin
        case (funct3_q[1:0])
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
    end

    assign mask    = {4'b0000, size_mask} << off;
    assign data    = {WORD_W'(0), wdata_q} << {off, 3'b000};
    assign split   = |mask[7:4];
    assign lo_addr = {addr_q[ADDR_W-1:2], 2'b00};
    assign hi_addr = lo_addr + ADDR_W'(4);

    // In LAST the final word is still on mem_rdata; fold it in so the result registers on entry to RESP.
    assign rword   = split ? {mem_rdata, buf_lo_q} : {buf_hi_q, mem_rdata};
    assign shifted = WORD_W'(rword >> {off, 3'b000});

    always_comb begin
        case (funct3_q)
            FUNC3_LB:  ext = {{24{shifted[7]}}, shifted[7:0]};
            FUNC3_LH:  ext = {{16{shifted[15]}}, shifted[15:0]};
            FUNC3_LBU: ext = {24'h000000, shifted[7:0]};
            FUNC3_LHU: ext = {16'h0000, shifted[15:0]};
            default:   ext = shifted;
        endcase
    end

    assign resp_rdata_d = store_q ? '0 : ext;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            store_q      <= 1'b0;
            funct3_q     <= 3'b000;
            addr_q       <= '0;
            wdata_q      <= '0;
            buf_lo_q     <= '0;
            buf_hi_q     <= '0;
            resp_rdata_q <= '0;
            err_q        <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        store_q      <= req_store;
                        funct3_q     <= req_funct3;
                        addr_q       <= req_addr;
                        wdata_q      <= req_wdata;
                        err_q        <= req_illegal;
                        resp_rdata_q <= '0;
                        state_q      <= req_illegal ? S_RESP : S_LO;
                    end
                end
                S_LO: begin
                    state_q <= split ? S_HI : S_LAST;
                end
                S_HI: begin
                    buf_lo_q <= mem_rdata;
                    state_q  <= S_LAST;
                end
                S_LAST: begin
                    if (split) begin
                        buf_hi_q <= mem_rdata;
                    end else begin
                        buf_lo_q <= mem_rdata;
                    end
                    resp_rdata_q <= resp_rdata_d;
                    state_q      <= S_RESP;
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Memory and response strobes decode from state; rst blanks them in the same cycle.
    always_comb begin
        req_ready  = (state_q == S_IDLE);
        mem_valid  = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = lo_addr;
        mem_be     = 4'b0000;
        mem_wdata  = data[WORD_W-1:0];
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        if (!rst) begin
            case (state_q)
                S_LO: begin
                    mem_valid = 1'b1;
                    mem_we    = store_q;
                    mem_be    = mask[3:0];
                end
                S_HI: begin
                    mem_valid = 1'b1;
                    mem_we    = store_q;
                    mem_addr  = hi_addr;
                    mem_be    = mask[7:4];
                    mem_wdata = data[PAIR_W-1:WORD_W];
                end
                S_RESP: begin
                    resp_valid = 1'b1;
                    resp_err   = err_q;
                end
                default: begin
                end
            endcase
        end
    end

    assign resp_rdata = resp_rdata_q;

endmodule
